// File: rtl/rns_pkg.sv
// Shared constants, CRT weights and helpers for the RNS reverse converter.
// The moduli (233, 239, 241, 251) are fixed; their product M must stay below 2^32.
package rns_pkg;

    localparam logic [63:0] M0     = 64'd233;
    localparam logic [63:0] M1     = 64'd239;
    localparam logic [63:0] M2     = 64'd241;
    localparam logic [63:0] M3     = 64'd251;
    localparam logic [63:0] M_FULL = M0 * M1 * M2 * M3;
    localparam logic [31:0] M_MOD  = M_FULL[31:0];

    typedef enum logic [1:0] {IDLE, STEP, ACC, DONE} state_e;

    // Brute-force inverse; only ever evaluated at elaboration for moduli < 256.
    function automatic logic [63:0] mod_inv(input logic [63:0] a, input logic [63:0] m);
        logic [63:0] r;
        r = 64'd0;
        for (int k = 1; k < 256; k++) begin
            if ((((a % m) * 64'(k)) % m) == 64'd1 && r == 64'd0)
                r = 64'(k);
        end
        return r;
    endfunction

    function automatic logic [31:0] crt_weight(input logic [63:0] m);
        logic [63:0] mi;
        mi = M_FULL / m;
        return 32'((mi * mod_inv(mi, m)) % M_FULL);
    endfunction

    localparam logic [31:0] W0 = crt_weight(M0);
    localparam logic [31:0] W1 = crt_weight(M1);
    localparam logic [31:0] W2 = crt_weight(M2);
    localparam logic [31:0] W3 = crt_weight(M3);

    function automatic logic [31:0] crt_w(input logic [1:0] i);
        case (i)
            2'd0:    return W0;
            2'd1:    return W1;
            2'd2:    return W2;
            default: return W3;
        endcase
    endfunction

    function automatic logic [7:0] modulus(input logic [1:0] i);
        case (i)
            2'd0:    return M0[7:0];
            2'd1:    return M1[7:0];
            2'd2:    return M2[7:0];
            default: return M3[7:0];
        endcase
    endfunction

    function automatic logic [7:0] rns_slot(input logic [31:0] x, input logic [1:0] i);
        return x[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/crt_step.sv
// One MSB-first modular multiply step: t_o = (2*t_i + b_i*w_i) mod M.
// Both inputs are below M, so the 34-bit sum is below 3M and two subtractions suffice.
module crt_step
    import rns_pkg::*;
(
    input  logic [31:0] t_i,
    input  logic        b_i,
    input  logic [31:0] w_i,
    output logic [31:0] t_o
);

    localparam logic [33:0] M34 = {2'b00, M_MOD};

    logic [33:0] sum;
    logic [33:0] red1;

    always_comb begin
        sum  = {1'b0, t_i, 1'b0} + (b_i ? {2'b00, w_i} : 34'd0);
        red1 = (sum >= M34) ? (sum - M34) : sum;
        t_o  = 32'((red1 >= M34) ? (red1 - M34) : red1);
    end

endmodule

// File: rtl/rns_to_int_seq.sv
// Sequential CRT reverse converter: 4 residues -> 32-bit integer, 36 compute cycles.
// A shared crt_step builds r_i*W_i bit-serially; ACC folds each product into the sum.
module rns_to_int_seq
    import rns_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_rns,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        err
);

    state_e      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] t_q, t_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  i_q, i_d;
    logic [2:0]  bit_q, bit_d;
    logic        err_q, err_d;

    logic [7:0]  res;
    logic [31:0] t_step;
    logic [32:0] acc_sum;
    logic        bad_in;

    assign res     = rns_slot(x_q, i_q);
    assign acc_sum = {1'b0, acc_q} + {1'b0, t_q};

    crt_step u_step (
        .t_i (t_q),
        .b_i (res[bit_q]),
        .w_i (crt_w(i_q)),
        .t_o (t_step)
    );

    always_comb begin
        bad_in = 1'b0;
        for (int k = 0; k < 4; k++)
            bad_in = bad_in | (rns_slot(x_rns, 2'(k)) >= modulus(2'(k)));
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        t_d     = t_q;
        acc_d   = acc_q;
        i_d     = i_q;
        bit_d   = bit_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_rns;
                    i_d     = 2'd0;
                    bit_d   = 3'd7;
                    t_d     = 32'd0;
                    acc_d   = 32'd0;
                    err_d   = bad_in;
                    state_d = STEP;
                end
            end
            STEP: begin
                t_d = t_step;
                if (bit_q == 3'd0) state_d = ACC;
                else               bit_d   = bit_q - 3'd1;
            end
            ACC: begin
                acc_d = (acc_sum >= {1'b0, M_MOD}) ? 32'(acc_sum - {1'b0, M_MOD})
                                                   : 32'(acc_sum);
                if (i_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 2'd1;
                    bit_d   = 3'd7;
                    t_d     = 32'd0;
                    state_d = STEP;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= 32'd0;
            t_q     <= 32'd0;
            acc_q   <= 32'd0;
            i_q     <= 2'd0;
            bit_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from registers; y/err are forced to 0 outside DONE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = (state_q == DONE && !err_q) ? acc_q : 32'd0;
    assign err       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_rns_to_int_seq.sv
// Directed and random checks for the sequential RNS-to-integer converter.
module tb_rns_to_int_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_rns;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] MFULL = 64'd3368562317;

    rns_to_int_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_rns     (x_rns),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Drives one word from IDLE, waits for out_valid, optionally releases it.
    task automatic convert(input logic [31:0] x, input bit release_it,
                           output logic [31:0] yv, output logic ev, output int lat);
        in_valid = 1'b1;
        x_rns    = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        yv = y;
        ev = err;
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_rns = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (y !== 32'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] xs  [5] = '{32'h00000000, 32'h01010101, 32'hF7242C44, 32'hFAF0EEE8, 32'h000000FF};
        logic [31:0] exy [5] = '{32'd0, 32'd1, 32'd1000, 32'd3368562316, 32'd0};
        logic        exe [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] yv;
        logic        ev;
        int          lat;
        for (int n = 0; n < 5; n++) begin
            convert(xs[n], 1'b1, yv, ev, lat);
            checks++; if (lat != 36) begin errors++; $display("FAIL latency x=%h: got %0d expected 36", xs[n], lat); end
            checks++; if (yv !== exy[n]) begin errors++; $display("FAIL y x=%h: got %0d expected %0d", xs[n], yv, exy[n]); end
            checks++; if (ev !== exe[n]) begin errors++; $display("FAIL err x=%h: got %b expected %b", xs[n], ev, exe[n]); end
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL back_to_idle x=%h: got in_ready=%b out_valid=%b expected 1 0", xs[n], in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] yv;
        logic        ev;
        int          lat;
        int          seen;
        convert(32'hF7242C44, 1'b0, yv, ev, lat);
        checks++; if (yv !== 32'd1000) begin errors++; $display("FAIL bp_first_y: got %0d expected 1000", yv); end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin in_valid = 1'b1; x_rns = 32'h01010101; end
            else        in_valid = 1'b0;
            @(posedge clk); #1;
            checks++; if (y !== 32'd1000 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold c=%0d: got y=%0d out_valid=%b expected 1000 1", c, y, out_valid);
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        seen = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL bp_no_accept: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] yv;
        logic        ev;
        int          lat;
        in_valid = 1'b1;
        x_rns    = 32'hF7242C44;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got in_ready=%b out_valid=%b y=%0d expected 1 0 0", in_ready, out_valid, y);
        end
        convert(32'h01010101, 1'b1, yv, ev, lat);
        checks++; if (yv !== 32'd1 || ev !== 1'b0 || lat != 36) begin
            errors++; $display("FAIL post_reset_conv: got y=%0d err=%b lat=%0d expected 1 0 36", yv, ev, lat);
        end
    endtask

    task automatic test_random();
        logic [63:0] xv;
        logic [31:0] packed_r;
        logic [31:0] yv;
        logic        ev;
        int          lat;
        for (int n = 0; n < 200; n++) begin
            xv = 64'($urandom) % MFULL;
            if (n == 0) xv = MFULL - 64'd2;
            packed_r = {8'(xv % 64'd251), 8'(xv % 64'd241), 8'(xv % 64'd239), 8'(xv % 64'd233)};
            convert(packed_r, 1'b1, yv, ev, lat);
            checks++; if ({32'd0, yv} !== xv || ev !== 1'b0 || lat != 36) begin
                errors++; $display("FAIL random n=%0d: got y=%0d err=%b lat=%0d expected %0d 0 36", n, yv, ev, lat, xv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
